// File: rtl/sap_pkg.sv
// Shared constants for the SAP-1 controller/sequencer: opcodes, T-state
// indices, control-word bit positions and an opcode classifier.
package sap_pkg;

  localparam int N_T = 6;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam int T1 = 0;
  localparam int T2 = 1;
  localparam int T3 = 2;
  localparam int T4 = 3;
  localparam int T5 = 4;
  localparam int T6 = 5;

  localparam logic [N_T-1:0] T_RESET = 6'b000001;

  localparam int CW_W  = 12;
  localparam int CW_CP = 0;
  localparam int CW_EP = 1;
  localparam int CW_LM = 2;
  localparam int CW_CE = 3;
  localparam int CW_LI = 4;
  localparam int CW_EI = 5;
  localparam int CW_LA = 6;
  localparam int CW_EA = 7;
  localparam int CW_SU = 8;
  localparam int CW_EU = 9;
  localparam int CW_LB = 10;
  localparam int CW_LO = 11;

  typedef logic [CW_W-1:0] ctrl_word_t;

  typedef enum logic [2:0] {
    OPC_LDA,
    OPC_ADD,
    OPC_SUB,
    OPC_OUT,
    OPC_HLT,
    OPC_NOP
  } op_class_e;

  // Every encoding not listed is a NOP with no execute-phase controls.
  function automatic op_class_e classify(input logic [3:0] op);
    op_class_e c;
    case (op)
      OP_LDA:  c = OPC_LDA;
      OP_ADD:  c = OPC_ADD;
      OP_SUB:  c = OPC_SUB;
      OP_OUT:  c = OPC_OUT;
      OP_HLT:  c = OPC_HLT;
      default: c = OPC_NOP;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/controller_sequencer_ring_counter.sv
// Six-bit one-hot T-state ring with hold and jump-to-T1; resets to T1.
module ring_counter
  import sap_pkg::*;
(
  input  logic           i_clock,
  input  logic           i_reset_n,
  input  logic           i_hold,
  input  logic           i_jump,
  output logic [N_T-1:0] o_state
);

  logic [N_T-1:0] state_q;
  logic [N_T-1:0] state_d;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) state_q <= T_RESET;
    else            state_q <= state_d;
  end

  // Hold outranks jump so a halted machine can never leave T4.
  always_comb begin
    state_d = {state_q[N_T-2:0], state_q[N_T-1]};
    if (i_hold)      state_d = state_q;
    else if (i_jump) state_d = T_RESET;
  end

  assign o_state = state_q;

  ring_onehot_a : assert property (@(posedge i_clock) disable iff (!i_reset_n)
    $onehot(state_q));

endmodule

// File: rtl/controller_sequencer.sv
// SAP-1 controller/sequencer: T-state ring plus opcode decode into the control
// word. Define SAP_SEQ_SKIP_IDLE_EN to return to T1 right after the last active state.
//
// state | meaning
// T1    | Ep, Lm : PC address into MAR
// T2    | Cp     : increment PC
// T3    | CE, Li : instruction into IR
// T4-T6 | execute, per opcode; HLT freezes in T4
module controller_sequencer
  import sap_pkg::*;
(
  input  logic       i_clock,
  input  logic       i_reset_n,
  input  logic [3:0] i_opcode,
  output logic [5:0] o_t_state,
  output logic       o_pc_increment,
  output logic       o_pc_send,
  output logic       o_mar_load,
  output logic       o_ram_send,
  output logic       o_ir_load,
  output logic       o_ir_send_address,
  output logic       o_a_load,
  output logic       o_a_send,
  output logic       o_alu_subtract,
  output logic       o_alu_send,
  output logic       o_b_load,
  output logic       o_out_load,
  output logic       o_halt
);

  logic [N_T-1:0] t_state;
  op_class_e      op_class;
  logic           hlt_now;
  logic           hold;
  logic           jump;
  logic           halt_q;
  logic           halt_d;
  ctrl_word_t     cw;

  assign op_class = classify(i_opcode);
  assign hlt_now  = t_state[T4] && (op_class == OPC_HLT);
  assign hold     = halt_q || hlt_now;

`ifdef SAP_SEQ_SKIP_IDLE_EN
  assign jump = (t_state[T5] && (op_class == OPC_LDA)) ||
                (t_state[T4] && ((op_class == OPC_OUT) || (op_class == OPC_NOP)));
`else
  assign jump = 1'b0;
`endif

  ring_counter u_ring (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .i_hold    (hold),
    .i_jump    (jump),
    .o_state   (t_state)
  );

  assign halt_d = halt_q || hlt_now;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) halt_q <= 1'b0;
    else            halt_q <= halt_d;
  end

  always_comb begin
    cw = '0;
    if (t_state[T1]) begin
      cw[CW_EP] = 1'b1;
      cw[CW_LM] = 1'b1;
    end
    if (t_state[T2]) cw[CW_CP] = 1'b1;
    if (t_state[T3]) begin
      cw[CW_CE] = 1'b1;
      cw[CW_LI] = 1'b1;
    end
    if (t_state[T4]) begin
      case (op_class)
        OPC_LDA, OPC_ADD, OPC_SUB: begin
          cw[CW_EI] = 1'b1;
          cw[CW_LM] = 1'b1;
        end
        OPC_OUT: begin
          cw[CW_EA] = 1'b1;
          cw[CW_LO] = 1'b1;
        end
        default: ;
      endcase
    end
    if (t_state[T5]) begin
      case (op_class)
        OPC_LDA: begin
          cw[CW_CE] = 1'b1;
          cw[CW_LA] = 1'b1;
        end
        OPC_ADD, OPC_SUB: begin
          cw[CW_CE] = 1'b1;
          cw[CW_LB] = 1'b1;
        end
        default: ;
      endcase
    end
    if (t_state[T6]) begin
      case (op_class)
        OPC_ADD: begin
          cw[CW_EU] = 1'b1;
          cw[CW_LA] = 1'b1;
        end
        OPC_SUB: begin
          cw[CW_SU] = 1'b1;
          cw[CW_EU] = 1'b1;
          cw[CW_LA] = 1'b1;
        end
        default: ;
      endcase
    end
    // Controls are silenced while reset is held, not just after the first edge.
    if (halt_q || !i_reset_n) cw = '0;
  end

  assign o_t_state         = t_state;
  assign o_pc_increment    = cw[CW_CP];
  assign o_pc_send         = cw[CW_EP];
  assign o_mar_load        = cw[CW_LM];
  assign o_ram_send        = cw[CW_CE];
  assign o_ir_load         = cw[CW_LI];
  assign o_ir_send_address = cw[CW_EI];
  assign o_a_load          = cw[CW_LA];
  assign o_a_send          = cw[CW_EA];
  assign o_alu_subtract    = cw[CW_SU];
  assign o_alu_send        = cw[CW_EU];
  assign o_b_load          = cw[CW_LB];
  assign o_out_load        = cw[CW_LO];
  assign o_halt            = halt_q || hlt_now;

  bus_single_driver_a : assert property (@(posedge i_clock) disable iff (!i_reset_n)
    $onehot0({cw[CW_EP], cw[CW_CE], cw[CW_EI], cw[CW_EA], cw[CW_EU]}));

endmodule

// File: tb/tb_controller_sequencer.sv
// Randomized bench for controller_sequencer against an instruction-step model.
// Honours SAP_SEQ_SKIP_IDLE_EN when it is defined for the build.
module tb_controller_sequencer;

  localparam logic [3:0] LDA = 4'h0;
  localparam logic [3:0] ADD = 4'h1;
  localparam logic [3:0] SUB = 4'h2;
  localparam logic [3:0] OUT = 4'hE;
  localparam logic [3:0] HLT = 4'hF;

  localparam logic [11:0] K_CP = 12'h800;
  localparam logic [11:0] K_EP = 12'h400;
  localparam logic [11:0] K_LM = 12'h200;
  localparam logic [11:0] K_CE = 12'h100;
  localparam logic [11:0] K_LI = 12'h080;
  localparam logic [11:0] K_EI = 12'h040;
  localparam logic [11:0] K_LA = 12'h020;
  localparam logic [11:0] K_EA = 12'h010;
  localparam logic [11:0] K_SU = 12'h008;
  localparam logic [11:0] K_EU = 12'h004;
  localparam logic [11:0] K_LB = 12'h002;
  localparam logic [11:0] K_LO = 12'h001;

  logic       i_clock = 1'b0;
  logic       i_reset_n;
  logic [3:0] i_opcode;
  logic [5:0] o_t_state;
  logic o_pc_increment, o_pc_send, o_mar_load, o_ram_send, o_ir_load;
  logic o_ir_send_address, o_a_load, o_a_send, o_alu_subtract, o_alu_send;
  logic o_b_load, o_out_load, o_halt;

  controller_sequencer dut (
    .i_clock           (i_clock),
    .i_reset_n         (i_reset_n),
    .i_opcode          (i_opcode),
    .o_t_state         (o_t_state),
    .o_pc_increment    (o_pc_increment),
    .o_pc_send         (o_pc_send),
    .o_mar_load        (o_mar_load),
    .o_ram_send        (o_ram_send),
    .o_ir_load         (o_ir_load),
    .o_ir_send_address (o_ir_send_address),
    .o_a_load          (o_a_load),
    .o_a_send          (o_a_send),
    .o_alu_subtract    (o_alu_subtract),
    .o_alu_send        (o_alu_send),
    .o_b_load          (o_b_load),
    .o_out_load        (o_out_load),
    .o_halt            (o_halt)
  );

  always #5 i_clock = ~i_clock;

  logic [11:0] ctl;
  logic [4:0]  drv;
  assign ctl = {o_pc_increment, o_pc_send, o_mar_load, o_ram_send, o_ir_load,
                o_ir_send_address, o_a_load, o_a_send, o_alu_subtract,
                o_alu_send, o_b_load, o_out_load};
  assign drv = {o_pc_send, o_ram_send, o_ir_send_address, o_a_send, o_alu_send};

  int n_checks = 0;
  int n_pass   = 0;

  // model state: position within the current instruction and the halt flag
  int         step;
  bit         halted;
  logic [3:0] cur_op;
  logic [3:0] op_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  function automatic logic [11:0] exp_ctl(input int s, input logic [3:0] op);
    logic [11:0] c;
    c = '0;
    case (s)
      0: c = K_EP | K_LM;
      1: c = K_CP;
      2: c = K_CE | K_LI;
      3: if (op == LDA || op == ADD || op == SUB) c = K_EI | K_LM;
         else if (op == OUT) c = K_EA | K_LO;
      4: if (op == LDA) c = K_CE | K_LA;
         else if (op == ADD || op == SUB) c = K_CE | K_LB;
      5: if (op == ADD) c = K_EU | K_LA;
         else if (op == SUB) c = K_SU | K_EU | K_LA;
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic int ilen(input logic [3:0] op);
`ifdef SAP_SEQ_SKIP_IDLE_EN
    if (op == LDA) return 5;
    if (op == ADD || op == SUB || op == HLT) return 6;
    return 4;
`else
    return 6;
`endif
  endfunction

  function automatic logic [3:0] rand_op();
    case ($urandom_range(0, 7))
      0: return LDA;
      1: return ADD;
      2: return SUB;
      3: return OUT;
      default: return 4'($urandom_range(3, 13));
    endcase
  endfunction

  // Called at a falling edge: check this cycle, then step the model and
  // drive the opcode for the next cycle.
  task automatic tick();
    logic [5:0] exp_t;
    #1;
    exp_t = halted ? 6'b001000 : (6'b000001 << step);
    chk("t_state", {26'd0, o_t_state}, {26'd0, exp_t});
    chk("controls", {20'd0, ctl}, {20'd0, (halted ? 12'h000 : exp_ctl(step, cur_op))});
    chk("halt", {31'd0, o_halt}, {31'd0, (halted || (step == 3 && cur_op == HLT))});
    chk("bus_single_driver", {31'd0, ($countones(drv) <= 1)}, 32'd1);
    chk("t_onehot", {31'd0, $onehot(o_t_state)}, 32'd1);
    if (!halted) begin
      if (step == 3 && cur_op == HLT) halted = 1'b1;
      else begin
        step++;
        if (step >= ilen(cur_op)) step = 0;
      end
    end
    if (!halted) begin
      if (step == 2) cur_op = (op_q.size() > 0) ? op_q.pop_front() : rand_op();
      else if (step < 2) cur_op = 4'($urandom_range(0, 15));
    end
    i_opcode = cur_op;
    @(negedge i_clock);
  endtask

  task automatic chk_reset(input string tag);
    #1;
    chk({tag, "_t"}, {26'd0, o_t_state}, 32'd1);
    chk({tag, "_ctl"}, {20'd0, ctl}, 32'd0);
    chk({tag, "_halt"}, {31'd0, o_halt}, 32'd0);
    step   = 0;
    halted = 1'b0;
  endtask

  initial begin
    i_reset_n = 1'b0;
    cur_op    = ADD;
    i_opcode  = cur_op;
    step      = 0;
    halted    = 1'b0;
    repeat (2) @(negedge i_clock);
    chk_reset("por");
    i_reset_n = 1'b1;

    op_q = '{LDA, SUB, ADD, 4'h7, OUT, LDA, OUT, 4'h3, SUB};
    repeat (60) tick();

    repeat (1000) tick();

    // reset in the middle of an ADD's T5
    op_q.push_back(ADD);
    for (int i = 0; i < 40; i++) begin
      if (step == 4 && cur_op == ADD && !halted) break;
      tick();
    end
    chk("add_t5_reached", {26'd0, o_t_state}, 32'h10);
    i_reset_n = 1'b0;
    chk_reset("mid_rst");
    @(negedge i_clock);
    chk_reset("mid_rst_held");
    i_reset_n = 1'b1;
    repeat (20) tick();

    // halt, then verify the freeze for ten more clocks
    op_q.push_back(HLT);
    for (int i = 0; i < 40; i++) begin
      if (halted) break;
      tick();
    end
    chk("halt_reached", {31'd0, o_halt}, 32'd1);
    repeat (10) tick();
    chk("halt_frozen_t4", {26'd0, o_t_state}, 32'h08);

    i_reset_n = 1'b0;
    chk_reset("halt_rst");
    @(negedge i_clock);
    i_reset_n = 1'b1;
    repeat (30) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/controller_sequencer.md
# controller_sequencer

SAP-1 controller/sequencer: the consuming end of the instruction register's opcode path. A six-state ring counter (T1–T6) steps each instruction through fetch and execute. The 4-bit opcode held in the instruction register is decoded into the one-cycle-per-state control word that drives the PC, MAR, RAM, IR, accumulator, ALU, B and output registers. It also issues the IR's load-instruction and send-address strobes.

## Interface

Parameters:
- none (state count and opcode encodings are fixed constants in the shared package)

Ports:
- i_clock  input  1  system clock; all state changes on rising edge
- i_reset_n  input  1  asynchronous, active-low reset
- i_opcode  input  4  registered opcode from the instruction register
- o_t_state  output  6  one-hot current T-state, bit0 = T1
- o_pc_increment  output  1  Cp: program counter increments on the next edge
- o_pc_send  output  1  Ep: PC drives bus
- o_mar_load  output  1  Lm: MAR loads from bus
- o_ram_send  output  1  CE: RAM drives bus
- o_ir_load  output  1  Li: IR loads instruction from bus
- o_ir_send_address  output  1  Ei: IR drives its address nibble onto bus
- o_a_load  output  1  La: accumulator loads from bus
- o_a_send  output  1  Ea: accumulator drives bus
- o_alu_subtract  output  1  Su: ALU subtracts (else adds)
- o_alu_send  output  1  Eu: ALU drives bus
- o_b_load  output  1  Lb: B register loads from bus
- o_out_load  output  1  Lo: output register loads from bus
- o_halt  output  1  processor halted; the clock gate upstream may use it

All controls are active-high.

## Operation

- Opcodes:
  - LDA = 4'h0
  - ADD = 4'h1
  - SUB = 4'h2
  - OUT = 4'hE
  - HLT = 4'hF
  - All others: NOP, meaning no execute-phase controls.
- Fetch, identical for every opcode:
  - T1: Ep, Lm
  - T2: Cp
  - T3: CE, Li
- Execute:
  - LDA: T4 Ei, Lm; T5 CE, La; T6 none
  - ADD: T4 Ei, Lm; T5 CE, Lb; T6 Eu, La
  - SUB: T4 Ei, Lm; T5 CE, Lb; T6 Su, Eu, La
  - OUT: T4 Ea, Lo; T5 and T6 none
  - HLT: on entry to T4, set the halt flag
  - NOP: T4–T6 none
- Ring advances T1→T2→…→T6→T1 every clock unless halted.
- Halt flag, registered:
  - Set at the edge ending a T4 whose opcode is HLT. o_halt is combinationally asserted during that T4 and stays registered high afterwards.
  - While halted: the ring freezes at T4 and every control output is 0 except o_halt.
  - Only reset clears the halt flag.
- Control outputs are combinational from the registered T-state, the halt flag and i_opcode. During T1–T3, i_opcode is don't-care.
- Reset, while i_reset_n is low:
  - o_t_state = 6'b000001
  - o_halt = 0
  - All control outputs forced to 0.
  - Normal T1 controls appear once reset is released.
- Reset mid-instruction: abandon the instruction immediately, return to T1 and clear halt. No partial execute state is retained.
- Only one bus driver may be active in any state (Ep, CE, Ei, Ea, Eu are mutually exclusive). This is a checked invariant.

## Timing

- One T-state per clock.
- Li is asserted in T3, so the IR captures the instruction at the T3→T4 edge. The new i_opcode is valid throughout T4–T6.
- Each load strobe takes effect at the rising edge that ends the state asserting it.
- Instruction latency: 6 cycles fixed (variable length with the configuration macro below).
- First T1 after reset release lasts one full cycle, starting from the release.
- i_opcode changing during T4–T6 is illegal; controls follow it combinationally, with no internal capture.

## Configuration

- Macro: SAP_SEQ_SKIP_IDLE_EN
- Defined: after the last active execute state the ring returns directly to T1.
  - LDA: 5 cycles
  - OUT and NOP: 4 cycles
  - ADD and SUB: 6 cycles
  - Skip decision is made from i_opcode in the current state.
- Undefined: every instruction takes exactly 6 cycles; idle states are traversed with all controls 0.

## Structure

- Shared package sap_pkg:
  - opcode localparams (OP_LDA, OP_ADD, OP_SUB, OP_OUT, OP_HLT)
  - T-state index constants T1..T6
  - control-word bit positions
- Sub-module ring_counter:
  - six-bit one-hot rotate
  - async active-low reset to 6'b000001
  - inputs: hold and jump-to-T1
- Decode logic lives in controller_sequencer.

## Test plan

- Reset asserted mid-T5 of an ADD → o_t_state = 6'b000001, all controls 0; after release T1 shows Ep=1, Lm=1.
- Opcode 4'h0 across one instruction → T1 Ep,Lm; T2 Cp; T3 CE,Li; T4 Ei,Lm; T5 CE,La; T6 no controls; next cycle T1.
- Opcode 4'h2 → T6 asserts Su, Eu, La together; Su is 0 in every other state; opcode 4'h1 gives T6 Eu, La with Su=0.
- Opcode 4'hF at T4 → o_halt=1; after 10 further clocks o_t_state stays 6'b001000 and all other controls stay 0; reset clears halt.
- Opcode 4'h7 → T4–T6 all controls 0; with SAP_SEQ_SKIP_IDLE_EN, opcode 4'h0 returns to T1 after 5 cycles and 4'hE after 4.
- Random opcode stream over 1000 cycles → at most one bus-driver enable asserted in every cycle; o_t_state always one-hot.
